// File: rtl/wb_interconnect_1xn.sv
// Single-master, N-slave classic Wishbone interconnect with base/limit address decode.
// Optional ACTIVE-state timeout abort is compiled in when WB_IC_TIMEOUT_EN is defined.
module wb_interconnect_1xn #(
    parameter int unsigned WB_ADDR_WIDTH  = 32,
    parameter int unsigned WB_DATA_WIDTH  = 32,
    parameter int unsigned N_SLAVES       = 4,
    parameter logic [N_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_ADDR_BASE  = {N_SLAVES*WB_ADDR_WIDTH{1'b0}},
    parameter logic [N_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_ADDR_LIMIT = {N_SLAVES*WB_ADDR_WIDTH{1'b0}},
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [WB_ADDR_WIDTH-1:0]            m_adr,
    input  logic [WB_DATA_WIDTH-1:0]            m_dat_w,
    output logic [WB_DATA_WIDTH-1:0]            m_dat_r,
    input  logic                                m_cyc,
    input  logic                                m_stb,
    input  logic                                m_we,
    input  logic [WB_DATA_WIDTH/8-1:0]          m_sel,
    output logic                                m_ack,
    output logic                                m_err,
    output logic [WB_ADDR_WIDTH-1:0]            s_adr,
    output logic [WB_DATA_WIDTH-1:0]            s_dat_w,
    output logic                                s_we,
    output logic [WB_DATA_WIDTH/8-1:0]          s_sel,
    output logic [N_SLAVES-1:0]                 s_cyc,
    output logic [N_SLAVES-1:0]                 s_stb,
    input  logic [N_SLAVES*WB_DATA_WIDTH-1:0]   s_dat_r,
    input  logic [N_SLAVES-1:0]                 s_ack,
    input  logic [N_SLAVES-1:0]                 s_err
);

    localparam int unsigned SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int unsigned TMO_W = 16;

    if (N_SLAVES < 1 || N_SLAVES > 16) begin : g_bad_n_slaves
        $error("wb_interconnect_1xn: N_SLAVES must be 1..16");
    end
    if (WB_DATA_WIDTH % 8 != 0) begin : g_bad_data_width
        $error("wb_interconnect_1xn: WB_DATA_WIDTH must be a multiple of 8");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_interconnect_1xn: TIMEOUT_CYCLES must be 2..65535");
    end

    typedef enum logic [1:0] {IDLE, ACTIVE, ERR} state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_idx_q, sel_idx_d;
    logic               hit_c;
    logic [SEL_W-1:0]   hit_idx_c;
    logic               sel_ack_c, sel_err_c;

    // Address decode; descending scan so the lowest matching index wins on overlap.
    always_comb begin
        hit_c     = 1'b0;
        hit_idx_c = '0;
        for (int i = int'(N_SLAVES) - 1; i >= 0; i--) begin
            if (m_adr >= SLAVE_ADDR_BASE[i*WB_ADDR_WIDTH +: WB_ADDR_WIDTH] &&
                m_adr <= SLAVE_ADDR_LIMIT[i*WB_ADDR_WIDTH +: WB_ADDR_WIDTH]) begin
                hit_c     = 1'b1;
                hit_idx_c = SEL_W'(i);
            end
        end
    end

    assign sel_ack_c = s_ack[sel_idx_q];
    assign sel_err_c = s_err[sel_idx_q];

    assign s_adr   = m_adr;
    assign s_dat_w = m_dat_w;
    assign s_we    = m_we;
    assign s_sel   = m_sel;

`ifdef WB_IC_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_hit_c;
    assign tmo_hit_c = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d   = state_q;
        sel_idx_d = sel_idx_q;
        s_cyc     = '0;
        s_stb     = '0;
        m_ack     = 1'b0;
        m_err     = 1'b0;
        m_dat_r   = '0;
`ifdef WB_IC_TIMEOUT_EN
        tmo_d     = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (m_cyc && m_stb) begin
                    if (hit_c) begin
                        sel_idx_d = hit_idx_c;
                        state_d   = ACTIVE;
`ifdef WB_IC_TIMEOUT_EN
                        tmo_d     = '0;
`endif
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            ACTIVE: begin
                s_cyc[sel_idx_q] = m_cyc;
                s_stb[sel_idx_q] = m_stb;
                m_dat_r = s_dat_r[sel_idx_q*WB_DATA_WIDTH +: WB_DATA_WIDTH];
                // A dropped m_cyc is a master abort: no response is passed back.
                m_err   = m_cyc & sel_err_c;
                m_ack   = m_cyc & sel_ack_c & ~sel_err_c;
                if (!m_cyc || sel_ack_c || sel_err_c) begin
                    state_d = IDLE;
                end
`ifdef WB_IC_TIMEOUT_EN
                else if (tmo_hit_c) begin
                    s_cyc   = '0;
                    s_stb   = '0;
                    m_err   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            ERR: begin
                m_err   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_idx_q <= '0;
`ifdef WB_IC_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sel_idx_q <= sel_idx_d;
`ifdef WB_IC_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

endmodule

// File: tb/tb_wb_interconnect_1xn.sv
// Scoreboard bench for wb_interconnect_1xn: 4-slave SRAM fabric plus a 2-slave overlap instance.
// Timeout checks run only when WB_IC_TIMEOUT_EN is defined.
module tb_wb_interconnect_1xn;

    typedef struct packed {
        logic        err;
        logic        chk;
        logic [31:0] dat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  m_adr = '0, m_dat_w = '0, m_dat_r;
    logic         m_cyc = 1'b0, m_stb = 1'b0, m_we = 1'b0;
    logic [3:0]   m_sel = 4'hF;
    logic         m_ack, m_err;
    logic [31:0]  s_adr, s_dat_w;
    logic         s_we;
    logic [3:0]   s_sel, s_cyc, s_stb, s_ack, s_err;
    logic [127:0] s_dat_r;

    logic [31:0]  mem [4][256];
    logic [3:0]   sack = '0;
    logic [7:0]   wcnt [4];
    logic [3:0]   never_ack = '0, err_mask = '0;
    int           wait_n = 0;

    exp_t         sb[$];
    int           total = 0, bad = 0;
    int           stb_cnt [4] = '{0, 0, 0, 0};
    logic [3:0]   prev_stb = '0, last_scyc = '0;
    logic         any_cyc = 1'b0;

    always #5 clk = ~clk;

    wb_interconnect_1xn #(
        .WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .N_SLAVES(4),
        .SLAVE_ADDR_BASE ({32'h3000, 32'h2000, 32'h1000, 32'h0000}),
        .SLAVE_ADDR_LIMIT({32'h3FFF, 32'h2FFF, 32'h1FFF, 32'h0FFF}),
        .TIMEOUT_CYCLES(16)
    ) u_dut (
        .clk(clk), .rst(rst), .m_adr(m_adr), .m_dat_w(m_dat_w), .m_dat_r(m_dat_r),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel), .m_ack(m_ack), .m_err(m_err),
        .s_adr(s_adr), .s_dat_w(s_dat_w), .s_we(s_we), .s_sel(s_sel), .s_cyc(s_cyc), .s_stb(s_stb),
        .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err)
    );

    // SRAM slave models: registered ack after wait_n extra cycles; err_mask turns ack into ack+err.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                sack[i] <= 1'b0;
                wcnt[i] <= 8'd0;
            end else if (s_cyc[i] && s_stb[i] && !sack[i] && !never_ack[i]) begin
                if (int'(wcnt[i]) >= wait_n) begin
                    sack[i] <= 1'b1;
                    wcnt[i] <= 8'd0;
                    if (s_we) mem[i][s_adr[9:2]] <= s_dat_w;
                end else begin
                    wcnt[i] <= wcnt[i] + 8'd1;
                end
            end else begin
                sack[i] <= 1'b0;
                wcnt[i] <= 8'd0;
            end
        end
    end

    assign s_ack = sack;
    assign s_err = sack & err_mask;

    always_comb begin
        s_dat_r = '0;
        for (int i = 0; i < 4; i++) s_dat_r[i*32 +: 32] = mem[i][s_adr[9:2]];
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endfunction

    // Monitor: pops the scoreboard on every master response; also tracks strobe pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_ack || m_err) begin
                if (sb.size() == 0) begin
                    check("unexpected_response", 32'({m_ack, m_err}), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("resp_err", 32'(m_err), 32'(e.err));
                    check("resp_ack", 32'(m_ack), 32'(!e.err));
                    if (e.chk) check("resp_data", m_dat_r, e.dat);
                end
            end
            for (int i = 0; i < 4; i++)
                if (s_stb[i] && !prev_stb[i]) stb_cnt[i]++;
            if (s_cyc != 4'd0) any_cyc = 1'b1;
        end
        prev_stb = s_stb;
    end

    task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                        input logic exp_err, input logic chk, input logic [31:0] exp_dat,
                        output int waits);
        logic resp;
        sb.push_back('{err: exp_err, chk: chk, dat: exp_dat});
        @(posedge clk); #1;
        m_adr = adr; m_we = we; m_dat_w = dat; m_cyc = 1'b1; m_stb = 1'b1;
        waits = 0;
        resp  = 1'b0;
        while (!resp && waits < 64) begin
            @(negedge clk);
            waits++;
            resp = m_ack | m_err;
            if (resp) last_scyc = s_cyc;
        end
        if (!resp) check("no_response", 32'd0, 32'd1);
        @(posedge clk); #1;
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
    endtask

    // Second instance with overlapping windows: slave0 0x0-0xFFF, slave1 0x800-0x17FF.
    logic [31:0] ov_adr = '0, ov_dat_r, ov_s_adr, ov_s_dat_w;
    logic        ov_cyc = 1'b0, ov_stb = 1'b0, ov_ack, ov_err, ov_s_we;
    logic [3:0]  ov_s_sel;
    logic [1:0]  ov_s_cyc, ov_s_stb, ov_sack = '0;

    wb_interconnect_1xn #(
        .WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .N_SLAVES(2),
        .SLAVE_ADDR_BASE ({32'h0800, 32'h0000}),
        .SLAVE_ADDR_LIMIT({32'h17FF, 32'h0FFF}),
        .TIMEOUT_CYCLES(16)
    ) u_ov (
        .clk(clk), .rst(rst), .m_adr(ov_adr), .m_dat_w(32'h0), .m_dat_r(ov_dat_r),
        .m_cyc(ov_cyc), .m_stb(ov_stb), .m_we(1'b0), .m_sel(4'hF), .m_ack(ov_ack), .m_err(ov_err),
        .s_adr(ov_s_adr), .s_dat_w(ov_s_dat_w), .s_we(ov_s_we), .s_sel(ov_s_sel),
        .s_cyc(ov_s_cyc), .s_stb(ov_s_stb),
        .s_dat_r({32'hB1B1B1B1, 32'hA0A0A0A0}), .s_ack(ov_sack), .s_err(2'b00)
    );

    always @(posedge clk) begin
        if (rst) ov_sack <= '0;
        else     ov_sack <= ov_s_cyc & ov_s_stb & ~ov_sack;
    end

    initial begin
        int w;
        int base_cnt [4];
        logic [31:0] ov_addrs [2];
        logic [1:0]  ov_exp_stb [2];
        logic [31:0] ov_exp_dat [2];

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_ack", 32'(m_ack), 32'd0);
        check("rst_m_err", 32'(m_err), 32'd0);
        check("rst_m_dat_r", m_dat_r, 32'd0);
        check("rst_s_cyc", 32'(s_cyc), 32'd0);
        check("rst_s_stb", 32'(s_stb), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Write then read 0x1004 on slave 1 only.
        base_cnt = stb_cnt;
        xfer(32'h1004, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, w);
        check("wr_latency", 32'(w), 32'd3);
        xfer(32'h1004, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, w);
        check("rd_latency", 32'(w), 32'd3);
        for (int i = 0; i < 4; i++)
            check($sformatf("stb_pulses_s%0d", i), 32'(stb_cnt[i] - base_cnt[i]), (i == 1) ? 32'd2 : 32'd0);

        // No aliasing between slave 0 and slave 3 at the same offset.
        base_cnt = stb_cnt;
        xfer(32'h0010, 1'b1, 32'h11111111, 1'b0, 1'b0, 32'h0, w);
        xfer(32'h3010, 1'b1, 32'h22222222, 1'b0, 1'b0, 32'h0, w);
        xfer(32'h0010, 1'b0, 32'h0, 1'b0, 1'b1, 32'h11111111, w);
        xfer(32'h3010, 1'b0, 32'h0, 1'b0, 1'b1, 32'h22222222, w);
        check("stb_pulses_s0_x2", 32'(stb_cnt[0] - base_cnt[0]), 32'd2);
        check("stb_pulses_s3_x2", 32'(stb_cnt[3] - base_cnt[3]), 32'd2);
        check("stb_pulses_s1_none", 32'(stb_cnt[1] - base_cnt[1]), 32'd0);

        // Unmapped address: one-cycle error, no slave cycle.
        any_cyc = 1'b0;
        xfer(32'h8000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, w);
        check("unmapped_latency", 32'(w), 32'd2);
        check("unmapped_no_cyc", 32'(any_cyc), 32'd0);

        // Simultaneous ack and err from the slave: error wins.
        err_mask = 4'b0001;
        xfer(32'h0010, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, w);
        err_mask = 4'b0000;

        // Reset while a read sits in wait states.
        wait_n = 5;
        @(posedge clk); #1;
        m_adr = 32'h1004; m_we = 1'b0; m_cyc = 1'b1; m_stb = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_s_cyc", 32'(s_cyc), 32'd0);
        check("midrst_s_stb", 32'(s_stb), 32'd0);
        check("midrst_m_ack", 32'(m_ack), 32'd0);
        check("midrst_m_err", 32'(m_err), 32'd0);
        rst = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
        wait_n = 0;
        xfer(32'h1004, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, w);
        check("postrst_latency", 32'(w), 32'd3);

`ifdef WB_IC_TIMEOUT_EN
        // Silent slave 2: abort on the 16th ACTIVE cycle, then a normal access.
        never_ack = 4'b0100;
        xfer(32'h2000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, w);
        check("tmo_latency", 32'(w), 32'd17);
        check("tmo_s_cyc_dropped", 32'(last_scyc), 32'd0);
        never_ack = 4'b0000;
        xfer(32'h0000, 1'b1, 32'h5A5A5A5A, 1'b0, 1'b0, 32'h0, w);
        xfer(32'h0000, 1'b0, 32'h0, 1'b0, 1'b1, 32'h5A5A5A5A, w);
`endif

        // Overlapping windows resolve to the lowest index.
        ov_addrs   = '{32'h0900, 32'h1000};
        ov_exp_stb = '{2'b01, 2'b10};
        ov_exp_dat = '{32'hA0A0A0A0, 32'hB1B1B1B1};
        for (int k = 0; k < 2; k++) begin
            int n;
            @(posedge clk); #1;
            ov_adr = ov_addrs[k]; ov_cyc = 1'b1; ov_stb = 1'b1;
            @(posedge clk); #1;
            check($sformatf("ov_stb_%0d", k), 32'(ov_s_stb), 32'(ov_exp_stb[k]));
            n = 0;
            while (!ov_ack && n < 16) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("ov_ack_%0d", k), 32'(ov_ack), 32'd1);
            check($sformatf("ov_dat_%0d", k), ov_dat_r, ov_exp_dat[k]);
            @(posedge clk); #1;
            ov_cyc = 1'b0; ov_stb = 1'b0;
        end

        repeat (4) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
